// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl -- IF-stage front-end sequencer.
// Owns the fetch PC and gates the instruction-memory read, the IF/ID load and
// the IF/ID flush. It reacts to back-end stalls, redirects and the decoded
// stop flag, and parks in HALT once the back end has drained.
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   backend_stall    back end cannot accept an instruction this cycle
//   redirect_valid   redirect request, with target redirect_pc
//   stop_det         stop flag currently held in IF/ID
//   pipe_empty       all back-end structures empty
//   pc_out           current fetch address (registered)
//   fetch_en         instruction-memory read enable
//   ifid_we          IF/ID load enable
//   ifid_flush       clear IF/ID contents
//   halted           core halted
//   stall_cnt        saturating count of cycles spent in STALL
module fetch_stage_ctrl #(
   parameter int                   PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
   parameter int                   FLUSH_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                backend_stall,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                stop_det,
   input  logic                pipe_empty,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                fetch_en,
   output logic                ifid_we,
   output logic                ifid_flush,
   output logic                halted,
   output logic [15:0]         stall_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      STALL = 3'd2,
      FLUSH = 3'd3,
      DRAIN = 3'd4,
      HALT  = 3'd5
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t     state;
   logic [3:0] flush_cnt;
   logic       fire;
   logic       redir_take;

   // Redirects are only honoured once the sequencer is live and not halted.
   always_comb begin
      redir_take = 1'b0;
      fire       = 1'b0;
      redir_take = redirect_valid & (state != HALT) & (state != IDLE);
      fire       = (state == RUN) & ~redirect_valid & ~stop_det & ~backend_stall;
   end

   assign fetch_en   = fire;
   assign ifid_we    = fire;
   assign ifid_flush = redir_take | (state == FLUSH);
   assign halted     = (state == HALT);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         pc_out    <= RESET_PC;
         flush_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (state == STALL && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;

         if (fire)
            pc_out <= pc_out + PC_WIDTH'(4);

         if (redir_take) begin
            // Latest redirect wins, including one arriving during FLUSH.
            pc_out    <= redirect_pc;
            flush_cnt <= FLUSH_LOAD;
            state     <= FLUSH;
         end else begin
            case (state)
               IDLE:  state <= RUN;
               RUN: begin
                  if (stop_det)           state <= DRAIN;
                  else if (backend_stall) state <= STALL;
               end
               STALL: begin
                  // Leaving STALL costs the current cycle as a restart bubble.
                  if (stop_det)            state <= DRAIN;
                  else if (!backend_stall) state <= RUN;
               end
               FLUSH: begin
                  if (flush_cnt == 4'd0) state <= RUN;
                  else                   flush_cnt <= flush_cnt - 4'd1;
               end
               DRAIN: begin
                  if (pipe_empty) state <= HALT;
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
module tb_fetch_stage_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        backend_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stop_det = 1'b0;
   logic        pipe_empty = 1'b0;
   logic [31:0] pc_out;
   logic        fetch_en, ifid_we, ifid_flush, halted;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_stage_ctrl #(
      .PC_WIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)
   ) dut (
      .clk(clk), .rstn(rstn), .backend_stall(backend_stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stop_det(stop_det), .pipe_empty(pipe_empty), .pc_out(pc_out),
      .fetch_en(fetch_en), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic        stall, redir;
      logic [31:0] rpc;
      logic        stop, empty;
      logic [31:0] pc;
      logic        fe, fl, h;
      logic [15:0] sc;
   } vec_t;

   vec_t tbl[33];

   function automatic vec_t mk(logic st, logic rd, logic [31:0] rp, logic sp, logic em,
                               logic [31:0] pc, logic fe, logic fl, logic h, logic [15:0] sc);
      vec_t v;
      v.stall = st; v.redir = rd; v.rpc = rp; v.stop = sp; v.empty = em;
      v.pc = pc; v.fe = fe; v.fl = fl; v.h = h; v.sc = sc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc, input logic fe,
                          input logic fl, input logic h, input logic [15:0] sc);
      chk({tag, " pc_out"}, pc_out, pc);
      chk({tag, " fetch_en"}, 32'(fetch_en), 32'(fe));
      chk({tag, " ifid_we"}, 32'(ifid_we), 32'(fe));
      chk({tag, " ifid_flush"}, 32'(ifid_flush), 32'(fl));
      chk({tag, " halted"}, 32'(halted), 32'(h));
      chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(sc));
   endtask

   task automatic drive(input logic st, input logic rd, input logic [31:0] rp,
                        input logic sp, input logic em);
      backend_stall = st; redirect_valid = rd; redirect_pc = rp;
      stop_det = sp; pipe_empty = em;
   endtask

   initial begin
      //       stall redir rpc       stop empty | pc        fe fl h sc
      tbl[0]  = mk(0, 1, 32'h500, 0, 0,  32'h0,   0, 0, 0, 0); // IDLE ignores redirect
      tbl[1]  = mk(0, 0, 32'h0,   0, 0,  32'h0,   1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 32'h0,   0, 0,  32'h4,   1, 0, 0, 0);
      tbl[3]  = mk(1, 0, 32'h0,   0, 0,  32'h8,   0, 0, 0, 0); // stall seen in RUN
      tbl[4]  = mk(1, 0, 32'h0,   0, 0,  32'h8,   0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 32'h0,   0, 0,  32'h8,   0, 0, 0, 1);
      tbl[6]  = mk(0, 0, 32'h0,   0, 0,  32'h8,   0, 0, 0, 2); // restart bubble
      tbl[7]  = mk(0, 0, 32'h0,   0, 0,  32'h8,   1, 0, 0, 3);
      tbl[8]  = mk(0, 0, 32'h0,   0, 0,  32'hC,   1, 0, 0, 3);
      tbl[9]  = mk(0, 1, 32'h100, 0, 0,  32'h10,  0, 1, 0, 3); // redirect in RUN
      tbl[10] = mk(0, 0, 32'h0,   0, 0,  32'h100, 0, 1, 0, 3);
      tbl[11] = mk(0, 0, 32'h0,   0, 0,  32'h100, 0, 1, 0, 3);
      tbl[12] = mk(0, 0, 32'h0,   0, 0,  32'h100, 1, 0, 0, 3);
      tbl[13] = mk(0, 0, 32'h0,   0, 0,  32'h104, 1, 0, 0, 3);
      tbl[14] = mk(0, 1, 32'h180, 0, 0,  32'h108, 0, 1, 0, 3);
      tbl[15] = mk(0, 1, 32'h200, 0, 0,  32'h180, 0, 1, 0, 3); // re-redirect in FLUSH
      tbl[16] = mk(0, 0, 32'h0,   0, 0,  32'h200, 0, 1, 0, 3);
      tbl[17] = mk(0, 0, 32'h0,   0, 0,  32'h200, 0, 1, 0, 3);
      tbl[18] = mk(0, 0, 32'h0,   0, 0,  32'h200, 1, 0, 0, 3);
      tbl[19] = mk(0, 0, 32'h0,   0, 0,  32'h204, 1, 0, 0, 3);
      tbl[20] = mk(0, 0, 32'h0,   1, 0,  32'h208, 0, 0, 0, 3); // stop -> DRAIN
      tbl[21] = mk(0, 0, 32'h0,   1, 0,  32'h208, 0, 0, 0, 3);
      tbl[22] = mk(0, 0, 32'h0,   1, 0,  32'h208, 0, 0, 0, 3);
      tbl[23] = mk(0, 0, 32'h0,   1, 0,  32'h208, 0, 0, 0, 3);
      tbl[24] = mk(0, 0, 32'h0,   1, 0,  32'h208, 0, 0, 0, 3);
      tbl[25] = mk(0, 1, 32'h40,  1, 1,  32'h208, 0, 1, 0, 3); // redirect beats pipe_empty
      tbl[26] = mk(1, 0, 32'h0,   1, 0,  32'h40,  0, 1, 0, 3); // stall/stop ignored in FLUSH
      tbl[27] = mk(1, 0, 32'h0,   1, 0,  32'h40,  0, 1, 0, 3);
      tbl[28] = mk(0, 0, 32'h0,   0, 0,  32'h40,  1, 0, 0, 3);
      tbl[29] = mk(0, 0, 32'h0,   1, 0,  32'h44,  0, 0, 0, 3);
      tbl[30] = mk(0, 0, 32'h0,   1, 1,  32'h44,  0, 0, 0, 3); // drained -> HALT
      tbl[31] = mk(1, 1, 32'h80,  0, 1,  32'h44,  0, 0, 1, 3); // HALT ignores inputs
      tbl[32] = mk(0, 1, 32'h90,  1, 0,  32'h44,  0, 0, 1, 3);

      // Reset state
      #2;
      chk_all("reset", 32'h0, 0, 0, 0, 16'd0);

      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 33; i++) begin
         drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].stop, tbl[i].empty);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fe, tbl[i].fl, tbl[i].h, tbl[i].sc);
         @(negedge clk);
      end

      // Reset from HALT, then asynchronous reset in the middle of a STALL.
      drive(0, 0, 0, 0, 0);
      rstn = 1'b0;
      #1;
      chk_all("halt_rst", 32'h0, 0, 0, 0, 16'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk_all("idle2", 32'h0, 0, 0, 0, 16'd0);
      @(negedge clk);
      #1;
      chk_all("run2", 32'h0, 1, 0, 0, 16'd0);
      @(negedge clk);
      drive(1, 0, 0, 0, 0);
      #1;
      chk_all("stall_enter", 32'h4, 0, 0, 0, 16'd0);
      repeat (6) @(negedge clk);
      #1;
      chk_all("stall5", 32'h4, 0, 0, 0, 16'd5);
      #2;
      rstn = 1'b0;
      #1;
      chk_all("async_rst", 32'h0, 0, 0, 0, 16'd0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      rstn = 1'b1;
      #1;
      chk_all("idle3", 32'h0, 0, 0, 0, 16'd0);
      @(negedge clk);
      #1;
      chk_all("run3", 32'h0, 1, 0, 0, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
